dezigzag_dequant: RTL and testbench

- Upstream neighbour of idct8. Accepts quantized DCT coefficients one per cycle in zigzag order from the entropy decoder.
- Multiplies each coefficient by its quantization-table entry and reorders it into natural (row-major) order in a ping-pong 8x8 buffer.
- Streams each completed block as 8 rows of 8 x 32-bit lanes onto idct8's 256-bit data_in / s_valid interface.

---
 rtl/jpeg_pkg.sv | 22 ++
 rtl/dezigzag_dequant_if.sv | 33 +++
 rtl/dzq_bank.sv | 42 ++++
 rtl/dezigzag_dequant.sv | 139 +++++++++++++
 tb/tb_dezigzag_dequant.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG decode datapath (zigzag map, widths, read FSM).
package jpeg_pkg;

  localparam int unsigned COEF_W_DEF = 16;
  localparam int unsigned Q_W_DEF    = 8;
  localparam int unsigned LANE_W_DEF = 32;

  // Natural (row-major) position of each zigzag index.
  localparam logic [5:0] ZZ_TO_NAT [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {StIdle, StEmit} rd_state_e;

endpackage

// File: rtl/dezigzag_dequant_if.sv
// Coefficient stream, quant-table write port and row output of dezigzag_dequant.
// s_eob exists only when DZQ_EOB_EN is defined.
interface dezigzag_dequant_if
  import jpeg_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned Q_W    = Q_W_DEF,
  parameter int unsigned LANE_W = LANE_W_DEF
) ();
  logic                     s_valid;
  logic                     s_ready;
  logic signed [COEF_W-1:0] s_data;
`ifdef DZQ_EOB_EN
  logic                     s_eob;
`endif
  logic                     q_we;
  logic [5:0]               q_addr;
  logic [Q_W-1:0]           q_data;
  logic                     m_valid;
  logic [8*LANE_W-1:0]      data_out;

`ifdef DZQ_EOB_EN
  modport master (output s_valid, s_data, s_eob, q_we, q_addr, q_data,
                  input  s_ready, m_valid, data_out);
  modport slave  (input  s_valid, s_data, s_eob, q_we, q_addr, q_data,
                  output s_ready, m_valid, data_out);
`else
  modport master (output s_valid, s_data, q_we, q_addr, q_data,
                  input  s_ready, m_valid, data_out);
  modport slave  (input  s_valid, s_data, q_we, q_addr, q_data,
                  output s_ready, m_valid, data_out);
`endif
endinterface

// File: rtl/dzq_bank.sv
// One 8x8 block store: scattered writes, full flag, 8-lane row read, zeroed on release.
module dzq_bank
  import jpeg_pkg::*;
#(
  parameter int unsigned LANE_W = LANE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [5:0]          waddr_i,
  input  logic [LANE_W-1:0]   wdata_i,
  input  logic                set_full_i,
  input  logic                clear_i,
  input  logic [2:0]          row_i,
  output logic [8*LANE_W-1:0] row_data_o,
  output logic                full_o
);
  logic [LANE_W-1:0] mem_q [64];
  logic              full_q;

  // Release zeroes the whole block so a short (early-ended) block reads back zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      for (int i = 0; i < 64; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      full_q <= 1'b0;
      for (int i = 0; i < 64; i++) mem_q[i] <= '0;
    end else begin
      if (we_i)       mem_q[waddr_i] <= wdata_i;
      if (set_full_i) full_q         <= 1'b1;
    end
  end

  always_comb begin
    row_data_o = '0;
    for (int c = 0; c < 8; c++) row_data_o[c*LANE_W +: LANE_W] = mem_q[{row_i, 3'(c)}];
  end

  assign full_o = full_q;

endmodule

// File: rtl/dezigzag_dequant.sv
// Dequantizes zigzag-ordered coefficients into a ping-pong 8x8 buffer and pushes
// natural-order rows to idct8. Define DZQ_EOB_EN to enable the early end-of-block input.
module dezigzag_dequant
  import jpeg_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned Q_W    = Q_W_DEF,
  parameter int unsigned LANE_W = LANE_W_DEF
) (
  input logic               clk,
  input logic               rst,
  dezigzag_dequant_if.slave bus
);
  localparam int unsigned ProdW = COEF_W + Q_W + 1;

  logic [Q_W-1:0]          q_table [64];
  logic [5:0]              wr_idx_q;
  logic                    wr_bank_q;
  logic                    prod_valid_q, prod_last_q, prod_bank_q;
  logic [5:0]              prod_pos_q;
  logic [LANE_W-1:0]       prod_q;
  rd_state_e               rd_state_q, rd_state_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [2:0]              rd_row_q, rd_row_d;
  logic [1:0]              full, landing, avail, clear;
  logic [8*LANE_W-1:0]     row_data [2];
  logic                    s_ready, accept, eob, blk_end;
  logic signed [ProdW-1:0] prod;

`ifdef DZQ_EOB_EN
  assign eob = bus.s_eob;
`else
  assign eob = 1'b0;
`endif

  assign s_ready = ~full[wr_bank_q];
  assign accept  = bus.s_valid & s_ready;
  assign blk_end = (wr_idx_q == 6'd63) | eob;
  // Zero-extend q so it multiplies as unsigned; 25-bit signed result is exact.
  assign prod    = $signed(bus.s_data) * $signed({1'b0, q_table[wr_idx_q]});

  // Not reset; a same-cycle write is seen only by later coefficients.
  always_ff @(posedge clk) begin
    if (bus.q_we) q_table[bus.q_addr] <= bus.q_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q     <= '0;
      wr_bank_q    <= 1'b0;
      prod_valid_q <= 1'b0;
      prod_last_q  <= 1'b0;
      prod_bank_q  <= 1'b0;
      prod_pos_q   <= '0;
      prod_q       <= '0;
    end else begin
      prod_valid_q <= accept;
      if (accept) begin
        prod_q      <= {{(LANE_W-ProdW){prod[ProdW-1]}}, prod};
        prod_pos_q  <= ZZ_TO_NAT[wr_idx_q];
        prod_bank_q <= wr_bank_q;
        prod_last_q <= blk_end;
        wr_idx_q    <= blk_end ? 6'd0 : wr_idx_q + 6'd1;
        if (blk_end) wr_bank_q <= ~wr_bank_q;
      end
    end
  end

  // A block becomes readable the cycle its last product lands, hiding the full-flag delay.
  assign landing = {prod_valid_q & prod_last_q & prod_bank_q,
                    prod_valid_q & prod_last_q & ~prod_bank_q};
  assign avail   = full | landing;

  dzq_bank #(.LANE_W(LANE_W)) u_bank0 (
    .clk        (clk),
    .rst        (rst),
    .we_i       (prod_valid_q & ~prod_bank_q),
    .waddr_i    (prod_pos_q),
    .wdata_i    (prod_q),
    .set_full_i (landing[0]),
    .clear_i    (clear[0]),
    .row_i      (rd_row_q),
    .row_data_o (row_data[0]),
    .full_o     (full[0])
  );

  dzq_bank #(.LANE_W(LANE_W)) u_bank1 (
    .clk        (clk),
    .rst        (rst),
    .we_i       (prod_valid_q & prod_bank_q),
    .waddr_i    (prod_pos_q),
    .wdata_i    (prod_q),
    .set_full_i (landing[1]),
    .clear_i    (clear[1]),
    .row_i      (rd_row_q),
    .row_data_o (row_data[1]),
    .full_o     (full[1])
  );

  // Reads alternate banks starting at 0, matching write order.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_row_d   = rd_row_q;
    clear      = '0;
    unique case (rd_state_q)
      StIdle: begin
        rd_row_d = 3'd0;
        if (avail[rd_bank_q]) rd_state_d = StEmit;
      end
      StEmit: begin
        rd_row_d = rd_row_q + 3'd1;
        if (rd_row_q == 3'd7) begin
          clear[rd_bank_q] = 1'b1;
          rd_bank_d        = ~rd_bank_q;
          rd_state_d       = avail[~rd_bank_q] ? StEmit : StIdle;
        end
      end
      default: rd_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= StIdle;
      rd_bank_q  <= 1'b0;
      rd_row_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      rd_row_q   <= rd_row_d;
    end
  end

  assign bus.s_ready  = s_ready;
  assign bus.m_valid  = (rd_state_q == StEmit);
  assign bus.data_out = (rd_state_q == StEmit) ? row_data[rd_bank_q] : '0;

endmodule

// File: tb/tb_dezigzag_dequant.sv
// Directed bench for dezigzag_dequant: ordering, dequant math, back-to-back, stall, reset.
`timescale 1ns/1ps
module tb_dezigzag_dequant;
  import jpeg_pkg::*;

  typedef struct packed {
    logic [15:0] d;
    logic        eob;
    logic        qwe;
    logic [5:0]  qa;
    logic [7:0]  qd;
  } stim_t;

  // Zigzag index found at natural positions of rows 0 and 1.
  localparam int EXP_R0 [8] = '{0, 1, 5, 6, 14, 15, 27, 28};
  localparam int EXP_R1 [8] = '{2, 4, 7, 13, 16, 26, 29, 42};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dezigzag_dequant_if #(.COEF_W(16), .Q_W(8), .LANE_W(32)) bus ();

  dezigzag_dequant #(.COEF_W(16), .Q_W(8), .LANE_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           last_acc = 0;
  int           stall_cycles = 0;
  stim_t        stim_q [$];
  logic [255:0] cap_row [$];
  int           cap_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input logic [255:0] r, input int c);
    return r[c*32 +: 32];
  endfunction

  task automatic push(input logic [15:0] d, input logic eob, input logic qwe,
                      input logic [5:0] qa, input logic [7:0] qd);
    stim_t s;
    s.d = d; s.eob = eob; s.qwe = qwe; s.qa = qa; s.qd = qd;
    stim_q.push_back(s);
  endtask

  task automatic push_block(input int base);
    for (int i = 0; i < 64; i++) push(16'(base + i), 1'b0, 1'b0, 6'd0, 8'd0);
  endtask

  // One cycle: sample outputs, then present the head of the stimulus queue.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.m_valid) begin
      cap_row.push_back(bus.data_out);
      cap_cyc.push_back(cyc);
    end
    bus.q_we = 1'b0;
    if (stim_q.size() > 0) begin
      bus.s_valid = 1'b1;
      bus.s_data  = stim_q[0].d;
`ifdef DZQ_EOB_EN
      bus.s_eob   = stim_q[0].eob;
`endif
      bus.q_we    = stim_q[0].qwe;
      bus.q_addr  = stim_q[0].qa;
      bus.q_data  = stim_q[0].qd;
      if (bus.s_ready) begin
        last_acc = cyc;
        void'(stim_q.pop_front());
      end else begin
        stall_cycles++;
      end
    end else begin
      bus.s_valid = 1'b0;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string tag);
    int budget = 0;
    while (stim_q.size() > 0 && budget < 5000) begin
      step();
      budget++;
    end
    chk({tag, "_drain"}, stim_q.size(), 0);
  endtask

  task automatic clear_cap();
    cap_row.delete();
    cap_cyc.delete();
  endtask

  task automatic qfill(input logic [7:0] v);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bus.q_we = 1'b1; bus.q_addr = 6'(i); bus.q_data = v;
    end
    @(negedge clk);
    bus.q_we = 1'b0;
  endtask

  task automatic qwrite(input logic [5:0] a, input logic [7:0] v);
    @(negedge clk);
    bus.q_we = 1'b1; bus.q_addr = a; bus.q_data = v;
    @(negedge clk);
    bus.q_we = 1'b0;
  endtask

  // Rows 0/1 and the last lane of a ramp block (coefficient = off + zigzag index).
  task automatic chk_block(input string tag, input int first, input int off);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("%s_r0c%0d", tag, c), lane(cap_row[first], c), 32'(off + EXP_R0[c]));
      chk($sformatf("%s_r1c%0d", tag, c), lane(cap_row[first+1], c), 32'(off + EXP_R1[c]));
    end
    chk({tag, "_r7c7"}, lane(cap_row[first+7], 7), 32'(off + 63));
  endtask

  initial begin
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.q_we = 1'b0; bus.q_addr = '0; bus.q_data = '0;
`ifdef DZQ_EOB_EN
    bus.s_eob = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_data_zero", 32'(bus.data_out == '0), 32'd1);
    rst = 1'b0;
    qfill(8'd1);

    // Ramp block: zigzag index comes out at its natural position.
    clear_cap();
    push_block(0);
    drain("t1");
    run(12);
    chk("t1_rows", cap_row.size(), 8);
    if (cap_row.size() == 8) begin
      chk("t1_first_cyc", cap_cyc[0], last_acc + 2);
      chk("t1_last_cyc", cap_cyc[7], last_acc + 9);
      chk_block("t1", 0, 0);
    end

    // -32768 * 255 = -8355840; q[0] rewritten during zz=1 (affects later blocks only).
    qwrite(6'd0, 8'd255);
    clear_cap();
    push(16'h8000, 1'b0, 1'b0, 6'd0, 8'd0);
    push(16'd0, 1'b0, 1'b1, 6'd0, 8'd3);
    for (int i = 2; i < 64; i++) push(16'd0, 1'b0, 1'b0, 6'd0, 8'd0);
    drain("t2");
    run(12);
    chk("t2_rows", cap_row.size(), 8);
    if (cap_row.size() == 8) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          chk($sformatf("t2_r%0dc%0d", r, c), lane(cap_row[r], c),
              (r == 0 && c == 0) ? 32'hFF80_8000 : 32'd0);
    end

    // Same-cycle write of q[0]=1 must not affect zz=0: 4 * 3 = 12.
    clear_cap();
    push(16'd4, 1'b0, 1'b1, 6'd0, 8'd1);
    for (int i = 1; i < 64; i++) push(16'd0, 1'b0, 1'b0, 6'd0, 8'd0);
    drain("t2b");
    run(12);
    chk("t2b_rows", cap_row.size(), 8);
    chk("t2b_r0c0", lane(cap_row[0], 0), 32'd12);

    // Three blocks back-to-back, no input stall.
    clear_cap();
    stall_cycles = 0;
    push_block(100); push_block(200); push_block(300);
    drain("t3");
    run(12);
    chk("t3_stall", stall_cycles, 0);
    chk("t3_rows", cap_row.size(), 24);
    if (cap_row.size() == 24) begin
      for (int b = 0; b < 3; b++) begin
        chk($sformatf("t3_b%0d_span", b), cap_cyc[8*b+7] - cap_cyc[8*b], 7);
        chk($sformatf("t3_b%0d_r0c0", b), lane(cap_row[8*b], 0), 32'(100 * (b + 1)));
        chk($sformatf("t3_b%0d_r0c2", b), lane(cap_row[8*b], 2), 32'(100 * (b + 1) + 5));
        chk($sformatf("t3_b%0d_r7c7", b), lane(cap_row[8*b+7], 7), 32'(100 * (b + 1) + 63));
      end
    end

    // Read side frozen: both banks fill, third block must stall without loss.
    clear_cap();
    stall_cycles = 0;
    force dut.rd_state_q = StIdle;
    push_block(1000); push_block(2000); push_block(3000);
    run(138);
    chk("t4_pending", stim_q.size(), 64);
    chk("t4_s_ready", 32'(bus.s_ready), 32'd0);
    chk("t4_stall", stall_cycles, 10);
    chk("t4_no_rows", cap_row.size(), 0);
    release dut.rd_state_q;
    drain("t4");
    run(12);
    chk("t4_rows", cap_row.size(), 24);
    if (cap_row.size() == 24) begin
      chk_block("t4a", 0, 1000);
      chk_block("t4b", 8, 2000);
      chk_block("t4c", 16, 3000);
    end

    // Reset after zz=30 of a partial block.
    for (int i = 0; i < 31; i++) push(16'(500 + i), 1'b0, 1'b0, 6'd0, 8'd0);
    drain("t5");
    step();
    rst = 1'b1;
    step();
    chk("t5_m_valid", 32'(bus.m_valid), 32'd0);
    chk("t5_s_ready", 32'(bus.s_ready), 32'd1);
    rst = 1'b0;
    clear_cap();
    push_block(900);
    drain("t5n");
    run(12);
    chk("t5_rows", cap_row.size(), 8);
    if (cap_row.size() == 8) chk_block("t5", 0, 900);

    // Reset during emission drops m_valid at once; nothing resumes.
    push_block(600);
    drain("t5b");
    run(4);
    chk("t5b_emitting", 32'(bus.m_valid), 32'd1);
    #1 rst = 1'b1;
    #1 chk("t5b_async_drop", 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_cap();
    run(12);
    chk("t5b_no_rows", cap_row.size(), 0);

`ifdef DZQ_EOB_EN
    // Early end of block: 5*2 = 10, -3*2 = -6, everything else zero.
    qfill(8'd2);
    clear_cap();
    push(16'd5, 1'b0, 1'b0, 6'd0, 8'd0);
    push(16'hFFFD, 1'b1, 1'b0, 6'd0, 8'd0);
    drain("t6");
    run(12);
    chk("t6_rows", cap_row.size(), 8);
    if (cap_row.size() == 8) begin
      chk("t6_first_cyc", cap_cyc[0], last_acc + 2);
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          chk($sformatf("t6_r%0dc%0d", r, c), lane(cap_row[r], c),
              (r == 0 && c == 0) ? 32'd10 : (r == 0 && c == 1) ? 32'hFFFF_FFFA : 32'd0);
    end
    chk("t6_s_ready", 32'(bus.s_ready), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
